rr_onehot_arbiter_8: RTL and testbench



---
 rtl/rr_onehot_arbiter_8.sv | 57 +++++
 tb/tb_rr_onehot_arbiter_8.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter_8.sv
// rr_onehot_arbiter_8: round-robin arbiter turning request pulses into one registered one-hot grant with valid/ready
module rr_onehot_arbiter_8 #(
  parameter int NREQ   = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [DROP_W-1:0] drop_cnt
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            r_state;
  logic [NREQ-1:0]   r_pend, r_grant, w_clr, w_cand;
  logic [2:0]        r_ptr, w_off, w_win;
  logic [DROP_W-1:0] r_drop;
  logic              r_valid, w_accept, w_drop;
  assign w_accept = r_valid & grant_ready;
  assign w_clr    = w_accept ? r_grant : '0;
  assign w_drop   = |(req & r_pend & ~w_clr);
  // Only registered pend competes; requests landing on the accept cycle wait for the next search.
  assign w_cand   = (r_state == IDLE) ? r_pend : r_pend & ~r_grant;
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (w_cand[r_ptr + 3'(i)]) w_off = 3'(i);
  end
  assign w_win = r_ptr + w_off;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_drop  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | req;
      if (w_drop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
      if (r_state == IDLE || grant_ready) begin
        if (|w_cand) begin
          r_grant <= NREQ'(1) << w_win;
          r_valid <= 1'b1;
          r_ptr   <= w_win + 3'd1;
          r_state <= GRANT;
        end else begin
          r_grant <= '0;
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      end
    end
  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign drop_cnt    = r_drop;
endmodule

// File: tb/tb_rr_onehot_arbiter_8.sv
// tb_rr_onehot_arbiter_8: randomized and directed checks against a behavioural round-robin model
module tb_rr_onehot_arbiter_8;
  logic       clk, rst_n, rdy;
  logic [7:0] req, grant, drop_cnt;
  logic       grant_valid;
  int checks = 0, errors = 0;

  rr_onehot_arbiter_8 dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .grant_valid(grant_valid), .grant_ready(rdy), .drop_cnt(drop_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  logic [7:0] m_pend;
  bit         m_valid;
  int         m_g, m_ptr, m_drop;

  function automatic void model_reset();
    m_pend = 0; m_valid = 0; m_g = 0; m_ptr = 0; m_drop = 0;
  endfunction

  function automatic void model_step();
    bit acc = m_valid && rdy;
    int clr = acc ? m_g : -1;
    bit hit = 0;
    logic [7:0] cand;
    for (int i = 0; i < 8; i++) if (req[i] && m_pend[i] && i != clr) hit = 1;
    if (hit && m_drop < 255) m_drop++;
    cand = !m_valid ? m_pend : acc ? (m_pend & ~(8'd1 << m_g)) : 8'd0;
    if (!m_valid || acc) begin
      m_valid = 0;
      for (int j = 0; j < 8 && !m_valid; j++)
        if (cand[(m_ptr + j) % 8]) begin m_g = (m_ptr + j) % 8; m_valid = 1; end
      if (m_valid) m_ptr = (m_g + 1) % 8;
    end
    for (int i = 0; i < 8; i++) m_pend[i] = (m_pend[i] && i != clr) || req[i];
  endfunction

  function automatic logic [7:0] exp_g();
    return m_valid ? 8'(1 << m_g) : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; req = 0; rdy = 0; model_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rdy = 0; req = 8'h3C; tick(); req = 8'h0C; tick(); req = 0; tick();
    req = 8'hFF; rst_n = 0; model_reset(); #1;
    checks++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || drop_cnt !== 8'h00) begin
      errors++; $display("FAIL reset_immediate grant=%h valid=%b drop=%0d expected 00/0/0", grant, grant_valid, drop_cnt);
    end
    tick(); tick(); rst_n = 1; req = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); checks++;
      if (grant !== 8'h00 || grant_valid !== 1'b0 || drop_cnt !== 8'h00) begin
        errors++; $display("FAIL reset_release c%0d grant=%h valid=%b drop=%0d expected 00/0/0", c, grant, grant_valid, drop_cnt);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] want;
    rdy = 1; req = 8'h08; tick(); req = 0;
    for (int c = 1; c <= 3; c++) begin
      tick(); want = (c == 1) ? 8'h08 : 8'h00; checks++;
      if (grant !== want || grant_valid !== (c == 1) || grant !== exp_g()) begin
        errors++; $display("FAIL single c%0d grant=%h valid=%b expected %h/%b", c, grant, grant_valid, want, c == 1);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    do_reset();
    rdy = 1; req = 8'hFF; tick(); req = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(); want = (c <= 8) ? 8'(1 << (c - 1)) : 8'h00; checks++;
      if (grant !== want || grant_valid !== (c <= 8) || grant !== exp_g()) begin
        errors++; $display("FAIL round_robin c%0d grant=%h valid=%b expected %h/%b", c, grant, grant_valid, want, c <= 8);
      end
    end
    checks++;
    if (m_ptr != 0 || drop_cnt !== 8'(m_drop)) begin
      errors++; $display("FAIL round_robin_end ptr=%0d drop=%0d expected ptr 0 drop %0d", m_ptr, drop_cnt, m_drop);
    end
  endtask

  task automatic test_backpressure();
    rdy = 0; req = 8'h04; tick(); req = 0;
    for (int c = 0; c < 10; c++) begin
      req = (c == 3) ? 8'h02 : 8'h00;
      tick(); checks++;
      if (grant !== 8'h04 || grant_valid !== 1'b1 || grant !== exp_g()) begin
        errors++; $display("FAIL stall c%0d grant=%h valid=%b expected 04/1", c, grant, grant_valid);
      end
    end
    req = 0; rdy = 1; tick(); checks++;
    if (grant !== 8'h02 || grant_valid !== 1'b1 || grant !== exp_g()) begin
      errors++; $display("FAIL fairness grant=%h valid=%b expected 02/1", grant, grant_valid);
    end
    tick(); checks++;
    if (grant_valid !== 1'b0 || grant !== 8'h00) begin
      errors++; $display("FAIL fairness_idle grant=%h valid=%b expected 00/0", grant, grant_valid);
    end
  endtask

  task automatic test_set_wins_drop();
    logic [7:0] d0;
    do_reset();
    rdy = 0; req = 8'h10; tick(); req = 0; tick();
    req = 8'h20; tick(); req = 0; tick(); req = 8'h20; tick(); req = 0;
    checks++;
    if (drop_cnt !== 8'd1 || drop_cnt !== 8'(m_drop) || grant !== 8'h10) begin
      errors++; $display("FAIL drop_once drop=%0d grant=%h expected 1/10", drop_cnt, grant);
    end
    rdy = 1; tick(); checks++;
    if (grant !== 8'h20 || grant_valid !== 1'b1) begin
      errors++; $display("FAIL next_20 grant=%h valid=%b expected 20/1", grant, grant_valid);
    end
    req = 8'h20; tick(); req = 0; tick(); checks++;
    if (grant !== 8'h20 || grant_valid !== 1'b1 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL set_wins grant=%h valid=%b drop=%0d expected 20/1/1", grant, grant_valid, drop_cnt);
    end
    rdy = 0; req = 8'hFF;
    for (int c = 0; c < 300; c++) tick();
    d0 = drop_cnt; req = 0; tick(); checks++;
    if (d0 !== 8'd255 || drop_cnt !== 8'd255 || m_drop != 255) begin
      errors++; $display("FAIL saturate drop=%0d/%0d expected 255", d0, drop_cnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    rdy = 0; req = 8'h07; tick(); req = 0; tick();
    checks++;
    if (grant_valid !== 1'b1 || grant !== 8'h01) begin
      errors++; $display("FAIL pre_reset grant=%h valid=%b expected 01/1", grant, grant_valid);
    end
    #2; rst_n = 0; model_reset(); #1; checks++;
    if (grant_valid !== 1'b0 || grant !== 8'h00 || drop_cnt !== 8'h00) begin
      errors++; $display("FAIL reset_mid grant=%h valid=%b drop=%0d expected 00/0/0", grant, grant_valid, drop_cnt);
    end
    tick(); tick(); rst_n = 1; rdy = 1;
    for (int c = 0; c < 5; c++) begin
      tick(); checks++;
      if (grant_valid !== 1'b0 || grant !== 8'h00) begin
        errors++; $display("FAIL post_reset c%0d grant=%h valid=%b expected 00/0", c, grant, grant_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      rdy = $urandom_range(0, 3) != 0;
      tick(); checks++;
      if (grant !== exp_g() || grant_valid !== m_valid || drop_cnt !== 8'(m_drop) || $countones(grant) > 1) begin
        errors++; $display("FAIL random c%0d grant=%h valid=%b drop=%0d expected %h/%b/%0d", c, grant, grant_valid, drop_cnt, exp_g(), m_valid, m_drop);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_set_wins_drop();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
